// File: rtl/ysyx_23060077_icache_pkg.sv
// Shared widths and FSM encoding for the instruction cache.
package ysyx_23060077_icache_pkg;

  localparam int unsigned ADDR_WIDTH    = 32;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned AXI_LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLookup = 2'd1,
    StRefill = 2'd2,
    StResp   = 2'd3
  } icache_state_e;

endpackage

// File: rtl/ysyx_23060077_icache.sv
// Direct-mapped read-only instruction cache; one AXI burst refill per missing line.
// Define YSYX_23060077_ICACHE_PERF_EN to add hit/miss counter ports.
module ysyx_23060077_icache
  import ysyx_23060077_icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ifu_r_valid_i,
  input  logic [ADDR_WIDTH-1:0]    ifu_r_addr_i,
  input  logic [AXI_LEN_WIDTH-1:0] ifu_r_len_i,
  output logic                     ifu_r_ready_o,
  output logic [DATA_WIDTH-1:0]    ifu_r_data_o,
  output logic                     ifu_r_last_o,
  output logic                     mem_r_valid_o,
  output logic [ADDR_WIDTH-1:0]    mem_r_addr_o,
  output logic [AXI_LEN_WIDTH-1:0] mem_r_len_o,
  input  logic                     mem_r_ready_i,
  input  logic [DATA_WIDTH-1:0]    mem_r_data_i,
  input  logic                     mem_r_last_i,
  input  logic                     fence_i_i
`ifdef YSYX_23060077_ICACHE_PERF_EN
  ,
  output logic [31:0]              perf_hit_o,
  output logic [31:0]              perf_miss_o
`endif
);

  localparam int unsigned WordBits = $clog2(LINE_WORDS);
  localparam int unsigned Off      = WordBits + 2;
  localparam int unsigned IdxBits  = $clog2(NUM_LINES);
  localparam int unsigned TagBits  = ADDR_WIDTH - Off - IdxBits;

  icache_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]     req_addr_q;
  logic                      flush_pend_q;
  logic [WordBits-1:0]       cnt_q;
  logic [NUM_LINES-1:0]      valid_q;
  logic [TagBits-1:0]        tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0]     data_q [NUM_LINES][LINE_WORDS];

  logic [IdxBits-1:0]        idx;
  logic [WordBits-1:0]       word;
  logic [TagBits-1:0]        req_tag;
  logic                      hit;
  logic                      beat;
  logic                      unused_bits;

  assign idx         = req_addr_q[Off +: IdxBits];
  assign word        = req_addr_q[2 +: WordBits];
  assign req_tag     = req_addr_q[ADDR_WIDTH-1 -: TagBits];
  assign hit         = valid_q[idx] && (tag_q[idx] == req_tag);
  assign beat        = (state_q == StRefill) && mem_r_ready_i;
  assign unused_bits = ^{ifu_r_len_i, req_addr_q[1:0]};

  always_comb begin
    state_d       = state_q;
    ifu_r_ready_o = 1'b0;
    ifu_r_last_o  = 1'b0;
    ifu_r_data_o  = '0;
    mem_r_valid_o = 1'b0;
    mem_r_addr_o  = '0;
    mem_r_len_o   = '0;
    unique case (state_q)
      StIdle: begin
        if (ifu_r_valid_i) state_d = StLookup;
      end
      StLookup: begin
        if (hit) begin
          ifu_r_ready_o = 1'b1;
          ifu_r_last_o  = 1'b1;
          ifu_r_data_o  = data_q[idx][word];
          state_d       = StIdle;
        end else begin
          state_d = StRefill;
        end
      end
      StRefill: begin
        mem_r_valid_o = 1'b1;
        mem_r_addr_o  = {req_addr_q[ADDR_WIDTH-1:Off], {Off{1'b0}}};
        mem_r_len_o   = AXI_LEN_WIDTH'(LINE_WORDS - 1);
        if (mem_r_ready_i && mem_r_last_i) state_d = StResp;
      end
      StResp: begin
        ifu_r_ready_o = 1'b1;
        ifu_r_last_o  = 1'b1;
        ifu_r_data_o  = data_q[idx][word];
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      req_addr_q   <= '0;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
      valid_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        // Invalidate before latching so a same-cycle request misses.
        if (fence_i_i || flush_pend_q) valid_q <= '0;
        flush_pend_q <= 1'b0;
        cnt_q        <= '0;
        if (ifu_r_valid_i) req_addr_q <= ifu_r_addr_i;
      end else if (fence_i_i) begin
        flush_pend_q <= 1'b1;
      end
      if (beat) begin
        cnt_q <= cnt_q + WordBits'(1);
        // A fence seen during the refill keeps the fresh line invalid.
        if (mem_r_last_i && !(flush_pend_q || fence_i_i)) valid_q[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      data_q[idx][cnt_q] <= mem_r_data_i;
      if (mem_r_last_i) tag_q[idx] <= req_tag;
    end
  end

`ifdef YSYX_23060077_ICACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else if (state_q == StLookup) begin
      if (hit) perf_hit_q <= perf_hit_q + 32'd1;
      else     perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
`endif

endmodule
